// File: rtl/rast_params.sv
// Shared rasterizer sizes, pipe depth, iterator state encoding and subsample codes.
package rast_params;

    localparam int SIGFIG     = 24;
    localparam int RADIX      = 10;
    localparam int VERTS      = 3;
    localparam int AXIS       = 3;
    localparam int COLORS     = 3;
    localparam int PIPES_ITER = 5;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } iter_state_t;

    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Step is 1<<(RADIX-k); an illegal (non-one-hot) code falls back to 1x.
    function automatic int unsigned ss_shift(input logic [3:0] ss);
        case (ss)
            SS_1X:   return 0;
            SS_4X:   return 1;
            SS_16X:  return 2;
            SS_64X:  return 3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/iter_delay.sv
// Fixed-depth register delay for a data word with a valid bit; latency DEPTH cycles.
// No backpressure; only the valid bits are reset, data is don't-care while invalid.
module iter_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][WIDTH-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/test_iterator.sv
// Raster sample iterator over a snapped bbox; one sample/cycle, R14 valid PIPES_ITER cycles after acceptance.
// halt_RnnnnL low stalls upstream; define RAST_ITER_PERF_CNT_EN to add the perf_samples_R14U counter.
module test_iterator #(
    parameter int SIGFIG     = rast_params::SIGFIG,
    parameter int RADIX      = rast_params::RADIX,
    parameter int VERTS      = rast_params::VERTS,
    parameter int AXIS       = rast_params::AXIS,
    parameter int COLORS     = rast_params::COLORS,
    parameter int PIPES_ITER = rast_params::PIPES_ITER
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
    input  logic                                          validTri_R10H,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R10S,
    input  logic        [3:0]                             subSample_RnnnnU,
    output logic                                          halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                          validSamp_R14H
`ifdef RAST_ITER_PERF_CNT_EN
    ,
    output logic        [31:0]                            perf_samples_R14U
`endif
);

    import rast_params::*;

    localparam int TW = VERTS * AXIS * SIGFIG;
    localparam int CW = COLORS * SIGFIG;
    localparam int DW = TW + CW + 2 * SIGFIG;

    iter_state_t              state_q, state_d;
    logic signed [SIGFIG-1:0] x_q, x_d, y_q, y_d;
    logic signed [SIGFIG-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
    logic        [SIGFIG-1:0] step_q, step_d;
    logic        [TW-1:0]     tri_q, tri_d;
    logic        [CW-1:0]     color_q, color_d;
    logic                     last;
    logic                     accept;
    logic        [DW-1:0]     dly_dat;

    assign last        = (x_q == urx_q) && (y_q == ury_q);
    assign halt_RnnnnL = !((state_q == TEST_STATE) && !last);
    assign accept      = validTri_R10H && halt_RnnnnL;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        llx_d   = llx_q;
        urx_d   = urx_q;
        ury_d   = ury_q;
        step_d  = step_q;
        tri_d   = tri_q;
        color_d = color_q;
        if ((state_q == TEST_STATE) && !last) begin
            if (x_q < urx_q) begin
                x_d = x_q + step_q;
            end else begin
                x_d = llx_q;
                y_d = y_q + step_q;
            end
        end else if (accept) begin
            // Also taken on the last-sample cycle, giving a zero-bubble handoff.
            state_d = TEST_STATE;
            x_d     = $signed(box_R10S[0][0]);
            y_d     = $signed(box_R10S[0][1]);
            llx_d   = $signed(box_R10S[0][0]);
            urx_d   = $signed(box_R10S[1][0]);
            ury_d   = $signed(box_R10S[1][1]);
            step_d  = SIGFIG'(1) << (RADIX - int'(ss_shift(subSample_RnnnnU)));
            tri_d   = tri_R10S;
            color_d = color_R10U;
        end else begin
            state_d = WAIT_STATE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q     <= x_d;
        y_q     <= y_d;
        llx_q   <= llx_d;
        urx_q   <= urx_d;
        ury_q   <= ury_d;
        step_q  <= step_d;
        tri_q   <= tri_d;
        color_q <= color_d;
    end

    iter_delay #(
        .WIDTH (DW),
        .DEPTH (PIPES_ITER)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (state_q == TEST_STATE),
        .data_i  ({tri_q, color_q, y_q, x_q}),
        .valid_o (validSamp_R14H),
        .data_o  (dly_dat)
    );

    assign {tri_R14S, color_R14U, sample_R14S} = dly_dat;

`ifdef RAST_ITER_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (validSamp_R14H && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_samples_R14U = perf_q;
`endif

endmodule

// File: doc/test_iterator.md
TEST_ITERATOR -- requirements
Module: test_iterator

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per coordinate and color word.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits; one pixel equals 1<<RADIX.
REQ-003 SHALL have parameters VERTS 3, AXIS 3, COLORS 3, meaning triangle vertices, axes per vertex and color channels.
REQ-004 SHALL have parameter PIPES_ITER, default 5, meaning total latency from acceptance to first sample output, minimum 2.
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-007 SHALL have port tri_R10S, input, VERTS×AXIS×SIGFIG signed, meaning the triangle from bbox.
REQ-008 SHALL have port color_R10U, input, COLORS×SIGFIG, meaning the triangle color.
REQ-009 SHALL have port validTri_R10H, input, 1, meaning the triangle and box are valid.
REQ-010 SHALL have port box_R10S, input, 2×2×SIGFIG signed, meaning the grid-snapped LL/UR corners, [0]=LL and [1]=UR.
REQ-011 SHALL have port subSample_RnnnnU, input, 4, meaning one-hot sample rate: 1000=1x, 0100=4x, 0010=16x, 0001=64x.
REQ-012 SHALL have port halt_RnnnnL, output, 1, meaning that when low, upstream holds all R10 inputs.
REQ-013 SHALL have port tri_R14S, output, same width as tri_R10S, meaning the triangle accompanying the sample.
REQ-014 SHALL have port color_R14U, output, same width as color_R10U, meaning the accompanying color.
REQ-015 SHALL have port sample_R14S, output, 2×SIGFIG signed, meaning the sample x/y.
REQ-016 SHALL have port validSamp_R14H, output, 1, meaning the R14 outputs are valid this cycle.

Function
REQ-017 SHALL implement FSM states WAIT_STATE and TEST_STATE.
REQ-018 SHALL accept a triangle on a rising edge where validTri_R10H=1 and halt_RnnnnL=1.
- On acceptance: latch tri, color, box and step.
- Load sample=LL.
- Enter TEST_STATE.
REQ-019 SHALL set step to 1<<(RADIX-k), with k=0,1,2,3 for 1x, 4x, 16x and 64x; a non-one-hot code SHALL be treated as 1x.
REQ-020 SHALL, in TEST_STATE, emit one sample per cycle in raster order.
- If x<URx: x+=step.
- Otherwise: x=LLx, y+=step.
REQ-021 SHALL treat x==URx and y==URy as the last sample.
- After the last sample the FSM SHALL return to WAIT_STATE.
- If a valid triangle is presented in that same cycle, it SHALL be accepted and the FSM SHALL stay in TEST_STATE with zero bubble.
REQ-022 SHALL drive halt_RnnnnL combinationally as 0 in TEST_STATE when the current sample is not last, and 1 otherwise.
REQ-023 SHALL emit a degenerate box (LL==UR) as exactly one sample.
REQ-024 SHALL ignore subSample_RnnnnU and box_R10S changes after acceptance.
REQ-025 SHALL delay iterator output through a register pipeline so that the sample emitted in the first TEST cycle appears at R14 exactly PIPES_ITER cycles after the acceptance edge.
- validSamp_R14H SHALL carry the TEST_STATE flag.
REQ-026 SHALL perform coordinate arithmetic at SIGFIG bits signed, with no saturation; boxes are pre-clipped upstream so overflow cannot occur.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=WAIT_STATE and clear all pipeline valid bits.
- halt_RnnnnL SHALL read 1 in the following cycle.
- validSamp_R14H SHALL read 0 until a new acceptance propagates.
REQ-028 SHALL discard an in-flight triangle and all pipelined samples on reset mid-operation.
REQ-029 SHALL keep data registers other than valid bits unreset; their values are don't-care while invalid.

Configuration
REQ-030 SHALL, with RAST_ITER_PERF_CNT_EN defined, add output perf_samples_R14U, 32 bits.
- It SHALL increment on each cycle validSamp_R14H=1 and saturate at 0xFFFFFFFF.
- rst SHALL clear it to 0.
REQ-031 SHALL, without RAST_ITER_PERF_CNT_EN, omit the port and counter entirely, with otherwise identical behaviour.

Structure
REQ-032 SHALL place the iter_state_t enum (WAIT_STATE, TEST_STATE) and the subsample code constants in package rast_params, alongside the existing size and pipe-depth constants.
REQ-033 SHALL implement the output delay as one parameterized sub-module iter_delay (width, depth, with a valid bit) that resets only its valid bits.

Verification
REQ-034 SHALL pass: 1x, LL=(0,0), UR=(1024,1024) -> samples (0,0),(1024,0),(0,1024),(1024,1024) on 4 consecutive cycles; halt low for the first 3 TEST cycles; first sample at acceptance+PIPES_ITER.
REQ-035 SHALL pass: 4x, same box -> 9 samples with step 512, in row-major order.
REQ-036 SHALL pass: degenerate box LL=UR=(2048,3072) -> one sample (2048,3072); halt never low.
REQ-037 SHALL pass: two triangles presented back to back -> the second is accepted on the last-sample cycle of the first, with no invalid gap at R14.
REQ-038 SHALL pass: rst asserted on the 3rd TEST cycle of a 16x triangle -> validSamp_R14H=0 from the next cycle; no residual samples; halt=1.
REQ-039 SHALL pass: with RAST_ITER_PERF_CNT_EN, run REQ-034 and REQ-035 -> perf_samples_R14U=13.
